// File: rtl/regfile_write_arbiter.sv
// Shares one register-bank write port between ALU, memory-load and I/O writeback
// sources, each with a one-entry slot, aged fixed-priority arbitration and a read-hazard flag.
module regfile_write_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int AGE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              io_valid,
  input  logic [ADDR_W-1:0] io_rd,
  input  logic [DATA_W-1:0] io_data,
  output logic              io_ready,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              hazard,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam int ALU = 0;
  localparam int MEM = 1;
  localparam int IO  = 2;
  localparam logic [1:0] AGE_LIM = 2'(AGE_MAX);

  logic [2:0]        in_valid;
  logic [ADDR_W-1:0] in_rd   [3];
  logic [DATA_W-1:0] in_data [3];

  logic [2:0]        full;
  logic [ADDR_W-1:0] slot_rd   [3];
  logic [DATA_W-1:0] slot_data [3];
  logic [1:0]        age       [3];

  logic [2:0]        base_ready;
  logic [2:0]        ready;
  logic [2:0]        accept;
  logic [2:0]        urgent;
  logic [2:0]        cand;
  logic [2:0]        grant;
  logic [1:0]        gidx;

  assign in_valid   = {io_valid, mem_valid, alu_valid};
  assign in_rd[ALU] = alu_rd;
  assign in_rd[MEM] = mem_rd;
  assign in_rd[IO]  = io_rd;
  assign in_data[ALU] = alu_data;
  assign in_data[MEM] = mem_data;
  assign in_data[IO]  = io_data;

  // Handshake: a slot captures rd/data on a rising edge where valid && ready;
  // ready never depends on the same source's valid. WAW guard: a nonzero rd
  // already held by another full slot, or offered this cycle by a
  // higher-priority accepted source, holds ready low to keep per-register order.
  always_comb begin
    base_ready = ~full;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (j != i && full[j] && in_rd[i] != '0 && slot_rd[j] == in_rd[i])
          base_ready[i] = 1'b0;
      end
    end
    ready      = base_ready;
    if (in_valid[MEM] && base_ready[MEM] && in_rd[ALU] != '0 && in_rd[MEM] == in_rd[ALU])
      ready[ALU] = 1'b0;
    if (in_valid[MEM] && base_ready[MEM] && in_rd[IO] != '0 && in_rd[MEM] == in_rd[IO])
      ready[IO] = 1'b0;
    if (in_valid[ALU] && base_ready[ALU] && in_rd[IO] != '0 && in_rd[ALU] == in_rd[IO])
      ready[IO] = 1'b0;
  end

  assign accept    = in_valid & ready;
  assign alu_ready = ready[ALU];
  assign mem_ready = ready[MEM];
  assign io_ready  = ready[IO];

  // Urgent slots form their own class; inside a class the order is mem > alu > io.
  always_comb begin
    for (int i = 0; i < 3; i++) urgent[i] = full[i] && (age[i] == AGE_LIM);
    cand  = (|urgent) ? urgent : full;
    grant = 3'b000;
    gidx  = 2'd0;
    if (cand[MEM]) begin
      grant = 3'b010;
      gidx  = 2'(MEM);
    end else if (cand[ALU]) begin
      grant = 3'b001;
      gidx  = 2'(ALU);
    end else if (cand[IO]) begin
      grant = 3'b100;
      gidx  = 2'(IO);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= '0;
      wr_en   <= 1'b0;
      wr_rd   <= '0;
      wr_data <= '0;
      for (int i = 0; i < 3; i++) begin
        slot_rd[i]   <= '0;
        slot_data[i] <= '0;
        age[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (grant[i]) begin
          full[i] <= 1'b0;
        end else if (full[i]) begin
          if (age[i] != AGE_LIM) age[i] <= age[i] + 2'd1;
        end else if (accept[i]) begin
          full[i]      <= 1'b1;
          slot_rd[i]   <= in_rd[i];
          slot_data[i] <= in_data[i];
          age[i]       <= '0;
        end
      end
      // An rd==0 grant drains the slot but never raises the bank write enable.
      wr_en <= (|grant) && (slot_rd[gidx] != '0);
      if (|grant) begin
        wr_rd   <= slot_rd[gidx];
        wr_data <= slot_data[gidx];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (full[i] && slot_rd[i] != '0 && (slot_rd[i] == rs || slot_rd[i] == rt))
        hazard = 1'b1;
    end
    if (wr_en && wr_rd != '0 && (wr_rd == rs || wr_rd == rt))
      hazard = 1'b1;
  end

  assign busy = (|full) || wr_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: latency, ordering, aging, WAW guard,
// hazard flag, rd==0 suppression and mid-operation reset.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, io_valid;
  logic [5:0]  alu_rd, mem_rd, io_rd;
  logic [31:0] alu_data, mem_data, io_data;
  logic        alu_ready, mem_ready, io_ready;
  logic [5:0]  rs, rt;
  logic        hazard, wr_en, busy;
  logic [5:0]  wr_rd;
  logic [31:0] wr_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(6), .AGE_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .io_valid(io_valid),   .io_rd(io_rd),   .io_data(io_data),   .io_ready(io_ready),
    .rs(rs), .rt(rt), .hazard(hazard),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; io_valid = 0;
  endtask

  initial begin
    int  seen;
    int  k;
    logic found;

    reset = 1; idle_inputs();
    alu_rd = 0; mem_rd = 0; io_rd = 0;
    alu_data = 0; mem_data = 0; io_data = 0;
    rs = 0; rt = 0;
    tick(); tick();

    // Reset state
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_rd", 32'(wr_rd), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hazard", 32'(hazard), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'({alu_ready, mem_ready, io_ready}), 32'h7);

    // 1: single ALU write, two-edge latency, ready low one cycle
    reset = 0;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1 chk("t1_ready_pre", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    #1 chk("t1_ready_full", 32'(alu_ready), 0);
    chk("t1_wr_en_n", 32'(wr_en), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_wr_en", 32'(wr_en), 1);
    chk("t1_wr_rd", 32'(wr_rd), 5);
    chk("t1_wr_data", wr_data, 32'hDEADBEEF);
    chk("t1_ready_back", 32'(alu_ready), 1);
    tick();
    chk("t1_wr_en_off", 32'(wr_en), 0);
    chk("t1_busy_off", 32'(busy), 0);

    // 2: three simultaneous accepts drain mem, alu, io
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h22;
    io_valid  = 1; io_rd  = 6; io_data  = 32'h33;
    #1 chk("t2_all_ready", 32'({alu_ready, mem_ready, io_ready}), 32'h7);
    tick();
    idle_inputs();
    #1 chk("t2_busy", 32'(busy), 1);
    tick();
    chk("t2_w1_rd", 32'(wr_rd), 4);
    chk("t2_w1_data", wr_data, 32'h22);
    tick();
    chk("t2_w2_rd", 32'(wr_rd), 3);
    chk("t2_w2_data", wr_data, 32'h11);
    tick();
    chk("t2_w3_rd", 32'(wr_rd), 6);
    chk("t2_w3_data", wr_data, 32'h33);
    chk("t2_w3_en", 32'(wr_en), 1);
    tick();
    chk("t2_busy_off", 32'(busy), 0);

    // 3: aging; mem and alu stream while io holds rd=7
    io_valid = 1; io_rd = 7; io_data = 32'h77;
    k = 0;
    mem_valid = 1; mem_rd = 6'(16 + k); mem_data = 32'(k);
    alu_valid = 1; alu_rd = 6'(32 + k); alu_data = 32'(k);
    tick();
    io_valid = 0;
    found = 0; seen = 0;
    for (int e = 1; e <= 6; e++) begin
      k++;
      mem_rd = 6'(16 + k); mem_data = 32'(k);
      alu_rd = 6'(32 + k); alu_data = 32'(k);
      tick();
      if (!found && wr_en && wr_rd == 6'd7) begin
        found = 1; seen = e;
      end
    end
    chk("t3_io_granted", 32'(found), 1);
    chk("t3_io_within5", 32'(found && seen <= 5), 1);
    idle_inputs();
    for (int e = 0; e < 10 && busy; e++) tick();
    chk("t3_drained", 32'(busy), 0);

    // 4: WAW guard on rd=9, including same-cycle collision
    mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
    alu_valid = 1; alu_rd = 9; alu_data = 32'hAA;
    #1 chk("t4_mem_ready", 32'(mem_ready), 1);
    chk("t4_alu_blocked_same", 32'(alu_ready), 0);
    tick();
    mem_valid = 0;
    #1 chk("t4_alu_blocked_pend", 32'(alu_ready), 0);
    tick();
    chk("t4_mem_write_rd", 32'(wr_rd), 9);
    chk("t4_mem_write_data", wr_data, 32'h99);
    chk("t4_alu_ready_after", 32'(alu_ready), 1);
    tick();
    alu_valid = 0;
    #1 chk("t4_gap", 32'(wr_en), 0);
    tick();
    chk("t4_alu_write_en", 32'(wr_en), 1);
    chk("t4_alu_write_rd", 32'(wr_rd), 9);
    chk("t4_alu_write_data", wr_data, 32'hAA);
    tick();

    // 5: hazard flag and rd==0 handling
    rs = 12; rt = 0;
    alu_valid = 1; alu_rd = 12; alu_data = 32'hC;
    #1 chk("t5_haz_before", 32'(hazard), 0);
    tick();
    alu_valid = 0;
    #1 chk("t5_haz_pending", 32'(hazard), 1);
    tick();
    chk("t5_haz_wr_en", 32'(hazard), 1);
    chk("t5_wr_en", 32'(wr_en), 1);
    tick();
    chk("t5_haz_clear", 32'(hazard), 0);
    rs = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
    tick();
    alu_valid = 0;
    #1 chk("t5_rd0_haz", 32'(hazard), 0);
    chk("t5_rd0_busy", 32'(busy), 1);
    tick();
    chk("t5_rd0_no_wr", 32'(wr_en), 0);
    tick();
    chk("t5_rd0_no_wr2", 32'(wr_en), 0);
    chk("t5_rd0_idle", 32'(busy), 0);
    rt = 20;
    mem_valid = 1; mem_rd = 20; mem_data = 32'h20;
    tick();
    mem_valid = 0;
    #1 chk("t5_haz_rt", 32'(hazard), 1);
    tick(); tick();
    rt = 0;

    // 6: reset with two full slots
    alu_valid = 1; alu_rd = 1; alu_data = 32'h101;
    mem_valid = 1; mem_rd = 2; mem_data = 32'h202;
    tick();
    idle_inputs();
    #1 chk("t6_busy_pre", 32'(busy), 1);
    reset = 1;
    tick();
    chk("t6_wr_en_rst", 32'(wr_en), 0);
    chk("t6_busy_rst", 32'(busy), 0);
    chk("t6_ready_rst", 32'({alu_ready, mem_ready, io_ready}), 32'h7);
    reset = 0;
    tick();
    chk("t6_wr_en_after", 32'(wr_en), 0);
    chk("t6_busy_after", 32'(busy), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
